// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between NUM_REQ byte sources, the arbiter and uart_tx.
//   req_data/req_valid/req_last : per-source byte offers (source side drives)
//   req_ready                   : per-source accept (arbiter drives)
//   tx_data/tx_valid/grant_id   : output register toward uart_tx
//   tx_ready                    : uart_tx accept
//   busy                        : arbiter locked or output register full
interface uart_tx_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    // Arbiter side
    modport slave (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy
    );

    // Sources / transmitter side
    modport master (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources.
// A granted source keeps the transmitter until req_last or MAX_BURST bytes.
// Ports:
//   uart_clk : clock
//   rst      : asynchronous active-high reset
//   bus      : uart_tx_arb_if slave modport (requester ports + uart_tx port)
module uart_tx_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic          uart_clk,
    input  logic          rst,
    uart_tx_arb_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       last_owner_q, last_owner_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;

    logic                  load_en;
    logic                  have_sel;
    logic [ID_W-1:0]       sel;
    logic [ID_W-1:0]       cand;
    logic                  accept;
    logic                  release_c;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    req_ready_c;

    // Selection, handshake and next-state logic
    always_comb begin
        load_en      = !tx_valid_q || bus.tx_ready;
        have_sel     = 1'b0;
        sel          = owner_q;
        cand         = '0;
        req_ready_c  = '0;
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        grant_id_d   = grant_id_q;

        if (state_q == LOCK) begin
            have_sel = 1'b1;
        end else begin
            // First valid source after last_owner, wrapping modulo NUM_REQ
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = ID_W'((32'(last_owner_q) + 32'd1 + i) % NUM_REQ);
                if (!have_sel && bus.req_valid[cand]) begin
                    have_sel = 1'b1;
                    sel      = cand;
                end
            end
        end

        if (!rst && have_sel) begin
            req_ready_c[sel] = load_en;
        end

        accept   = have_sel && bus.req_valid[sel] && load_en;
        sel_data = bus.req_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
        // burst_cnt counts bytes already taken in this grant, so MAX_BURST-1 marks the final one
        release_c = bus.req_last[sel] || (burst_cnt_q == CNT_W'(MAX_BURST - 1));

        if (accept) begin
            tx_data_d  = sel_data;
            tx_valid_d = 1'b1;
            grant_id_d = sel;
            if (release_c) begin
                state_d      = IDLE;
                last_owner_d = sel;
                burst_cnt_d  = '0;
            end else begin
                state_d     = LOCK;
                owner_d     = sel;
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end else if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end

        busy_d = (state_d == LOCK) || tx_valid_d;
    end

    // State and output registers
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= ID_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus random traffic
// compared against a transaction-level round-robin model.
module tb_uart_tx_arb;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .uart_clk (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner = -1 means nobody holds the transmitter
    int          m_owner;
    int          m_last;
    int          m_cnt;
    logic        m_txv;
    logic [DW-1:0] m_txd;
    int          m_gid;

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_cnt   = 0;
        m_txv   = 1'b0;
        m_txd   = '0;
        m_gid   = 0;
    endtask

    function automatic int pick(input logic [NR-1:0] v);
        if (m_owner >= 0) return m_owner;
        for (int k = 1; k <= int'(NR); k++) begin
            if (v[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR*DW-1:0] pk(input int idx, input logic [DW-1:0] b);
        logic [NR*DW-1:0] r;
        r = '0;
        r[idx*DW +: DW] = b;
        return r;
    endfunction

    // One clock of stimulus; called and returns at a falling edge
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic [NR*DW-1:0] d, input logic tr);
        int sel;
        logic ld;
        logic [NR-1:0] exp_rdy;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.tx_ready  = tr;
        #1;
        sel = pick(v);
        ld  = !m_txv || tr;
        exp_rdy = '0;
        if (sel >= 0 && ld) exp_rdy[sel] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (sel >= 0 && ld && v[sel]) begin
            m_txd = d[sel*DW +: DW];
            m_txv = 1'b1;
            m_gid = sel;
            m_cnt++;
            if (l[sel] || m_cnt == int'(MB)) begin
                m_owner = -1;
                m_last  = sel;
                m_cnt   = 0;
            end else begin
                m_owner = sel;
            end
        end else if (m_txv && tr) begin
            m_txv = 1'b0;
        end
        @(negedge clk);
        check("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        check("tx_data",  32'(bus.tx_data),  32'(m_txd));
        check("grant_id", 32'(bus.grant_id), 32'(m_gid));
        check("busy",     32'(bus.busy),     32'((m_owner >= 0) || m_txv));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [DW-1:0] hold_d;
    logic [NR*DW-1:0] d;
    int exp_gid[11] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0};

    initial begin
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        // Reset values while held
        check("rst_ready",    32'(bus.req_ready), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid),  32'd0);
        check("rst_tx_data",  32'(bus.tx_data),   32'd0);
        check("rst_grant",    32'(bus.grant_id),  32'd0);
        check("rst_busy",     32'(bus.busy),      32'd0);
        rst = 1'b0;

        // Single byte, single source
        step(4'b0100, 4'b0100, pk(2, 8'h5A), 1'b1);
        check("single_data",  32'(bus.tx_data),  32'h5A);
        check("single_grant", 32'(bus.grant_id), 32'd2);
        step(4'b0000, 4'b0000, '0, 1'b1);
        check("single_idle",  32'(bus.busy),     32'd0);

        // Fair rotation from a fresh reset
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b1111, 32'($urandom()), 1'b1);
            check("rot_grant", 32'(bus.grant_id), 32'(k % 4));
        end

        // Message lock: source 1 keeps the line while source 0 waits
        step(4'b0010, 4'b0000, pk(1, 8'h11), 1'b1);
        check("lock_d0", 32'(bus.tx_data), 32'h11);
        step(4'b0011, 4'b0001, pk(1, 8'h22) | pk(0, 8'hA0), 1'b1);
        check("lock_d1", 32'(bus.tx_data), 32'h22);
        step(4'b0011, 4'b0011, pk(1, 8'h33) | pk(0, 8'hA0), 1'b1);
        check("lock_d2", 32'(bus.tx_data), 32'h33);
        step(4'b0001, 4'b0001, pk(0, 8'hA0), 1'b1);
        check("lock_d3", 32'(bus.tx_data), 32'hA0);

        // Burst preemption after MB bytes
        for (int c = 0; c < 11; c++) begin
            logic [DW-1:0] b0;
            b0 = (c <= 4) ? DW'(8'hB0 + c) : DW'(8'hB0 + c - 1);
            step((c == 0) ? 4'b0001 : (c <= 4 ? 4'b1001 : 4'b0001), 4'b1000,
                 pk(0, b0) | pk(3, 8'hC3), 1'b1);
            check("burst_grant", 32'(bus.grant_id), 32'(exp_gid[c]));
            check("burst_data",  32'(bus.tx_data),
                  (c == 4) ? 32'hC3 : ((c < 4) ? 32'(8'hB0 + c) : 32'(8'hB0 + c - 1)));
        end

        // Back-pressure while source 0 still holds the lock
        step(4'b0001, 4'b0000, pk(0, 8'hD0), 1'b1);
        hold_d = m_txd;
        for (int c = 0; c < 20; c++) begin
            step(4'b1111, 4'b0000, 32'($urandom()), 1'b0);
            check("bp_hold_data",  32'(bus.tx_data),  32'(hold_d));
            check("bp_hold_grant", 32'(bus.grant_id), 32'd0);
        end
        step(4'b0001, 4'b0001, pk(0, 8'hD1), 1'b1);
        check("bp_reload", 32'(bus.tx_data), 32'hD1);

        // Reset in the middle of a locked message from source 2
        step(4'b0100, 4'b0000, pk(2, 8'hE0), 1'b1);
        step(4'b0100, 4'b0000, pk(2, 8'hE1), 1'b1);
        bus.req_valid = 4'b0100;
        bus.req_data  = pk(2, 8'hE2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", 32'(bus.tx_valid),  32'd0);
        check("mid_rst_busy",     32'(bus.busy),      32'd0);
        check("mid_rst_ready",    32'(bus.req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b0101, 4'b0101, pk(0, 8'hF0) | pk(2, 8'hF2), 1'b1);
        check("post_rst_grant", 32'(bus.grant_id), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            d = 32'($urandom());
            step(NR'($urandom()), NR'($urandom() & $urandom()), d,
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
